run_dump_sequencer: RTL
=======================

Name: run_dump_sequencer

Overview:
Synthesizable run controller for the pipelined processor test flow. It holds the core in reset, releases it for a bounded run (stopping early on halt), then walks data memory and the register file and streams every word out on a valid/ready dump port. It sits beside the processor in the top-level bench/FPGA harness and replaces hand-counted clock edges and direct hierarchical dumps.

Parameters:
DATA_W, 32, width of memory and register words
MEM_DEPTH, 64, data memory words dumped (addresses 0..MEM_DEPTH-1)
REG_COUNT, 32, registers dumped (indices 0..REG_COUNT-1)
RESET_CYCLES, 1, cycles proc_reset is held after start (>=1)
MAX_CYCLES, 32, run-cycle limit before forced stop (>=1)
CYC_W, 16, cycle counter width; must hold MAX_CYCLES

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high
start  in  1  one-cycle pulse; begins a sequence from IDLE or DONE
halt  in  1  processor halt indication, sampled only in RUN
proc_reset  out  1  reset to processor core
run_en  out  1  processor clock-enable; high only in RUN
mem_rd_addr  out  clog2(MEM_DEPTH)  data memory read address
mem_rd_data  in  DATA_W  memory read data, valid 1 cycle after address
reg_rd_addr  out  clog2(REG_COUNT)  register file read address
reg_rd_data  in  DATA_W  register read data, valid 1 cycle after address
dump_valid  out  1  dump word available
dump_ready  in  1  consumer accepts word when valid&ready
dump_data  out  DATA_W  dump word
dump_sel  out  1  0 = memory word, 1 = register word
dump_index  out  clog2(max(MEM_DEPTH,REG_COUNT))  address of current word
dump_last  out  1  high with final register word
done  out  1  sequence complete
timeout  out  1  run ended by MAX_CYCLES, not halt
cycle_count  out  CYC_W  RUN cycles executed in last/current run

Behaviour:
- Single clock clk; reset asynchronous, active-high.
- Reset values: state IDLE, proc_reset=1, run_en=0, dump_valid=0, dump_last=0, done=0, timeout=0, cycle_count=0, addresses 0, dump_data 0.
- States: IDLE, RST, RUN, FETCH, PRESENT, DONE.
- IDLE: proc_reset=1. start -> RST; clears done, timeout, cycle_count.
- RST: proc_reset=1 for exactly RESET_CYCLES cycles, then RUN.
- RUN: proc_reset=0, run_en=1; cycle_count increments each RUN cycle. Leave RUN when halt=1 (timeout=0) or when cycle_count reaches MAX_CYCLES (timeout=1). Both in same cycle: halt wins, timeout=0. The exiting cycle counts, so an immediate halt gives cycle_count=1. Next state FETCH, region memory, index 0.
- After RUN: run_en=0, proc_reset=0 (core frozen, state readable).
- FETCH: drive address for current region/index; next cycle -> PRESENT capturing rd_data into dump_data.
- PRESENT: dump_valid=1; dump_data/sel/index/last stable until dump_ready. On accept: advance index; at memory end switch to register region index 0; after last register -> DONE; else -> FETCH. Minimum 2 cycles per word; no words dropped or duplicated under any backpressure.
- dump_last=1 only in PRESENT for register REG_COUNT-1.
- DONE: done=1, proc_reset=1; cycle_count/timeout hold. start -> RST (new sequence).
- start in RST/RUN/FETCH/PRESENT ignored.
- Asynchronous reset in any state (mid-run or mid-dump) returns to reset values immediately; the partial dump is abandoned and no further word is presented.
- Total accepted words per sequence = MEM_DEPTH + REG_COUNT.

Decomposition:
- Package run_dump_pkg: state enum, DUMP_SEL_MEM=0 / DUMP_SEL_REG=1, clog2-based width constants.
- Sub-module dump_walker: region/index counter plus FETCH/PRESENT handshake; parent keeps IDLE/RST/RUN/DONE control and cycle counter.

Test Plan:
- Defaults, halt never asserted, dump_ready=1 -> proc_reset high 1 cycle, RUN 32 cycles, timeout=1, cycle_count=32, 96 words (64 mem, 32 reg), dump_last on reg 31, done=1.
- halt asserted on 10th RUN cycle -> cycle_count=10, timeout=0, run_en low next cycle, dump starts at mem index 0.
- halt on 32nd RUN cycle (limit reached simultaneously) -> timeout=0, cycle_count=32.
- dump_ready random ~30% with memory model addr*3 and regs idx+100 -> exact ordered sequence, data/index stable while valid&!ready.
- Reset asserted mid-dump at mem index 20 -> dump_valid=0, proc_reset=1, done=0 immediately; new start restarts at cycle_count=0.
- start pulsed during RUN and PRESENT -> ignored; start in DONE -> second full sequence, done cleared.

Source files
------------

// File: rtl/run_dump_pkg.sv
// Shared types and width helpers for the run/dump sequencer and its dump walker.
package run_dump_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RST,
        ST_RUN,
        ST_FETCH,
        ST_PRESENT,
        ST_DONE
    } state_t;

    localparam logic DUMP_SEL_MEM = 1'b0;
    localparam logic DUMP_SEL_REG = 1'b1;

    // Bits needed to index n entries; never below 1 so depth-1 tables still get a port.
    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/dump_walker.sv
// Walks data memory then the register file, presenting one word per valid/ready beat.
// Read data is sampled on the edge that ends FETCH, one cycle after the address is driven.
module dump_walker
    import run_dump_pkg::*;
#(
    parameter  int DATA_W    = 32,
    parameter  int MEM_DEPTH = 64,
    parameter  int REG_COUNT = 32,
    localparam int MA_W      = addr_w(MEM_DEPTH),
    localparam int RA_W      = addr_w(REG_COUNT),
    localparam int IDX_W     = addr_w(max_int(MEM_DEPTH, REG_COUNT))
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              begin_walk,
    output logic              walk_done,
    output logic [MA_W-1:0]   mem_rd_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic [RA_W-1:0]   reg_rd_addr,
    input  logic [DATA_W-1:0] reg_rd_data,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [DATA_W-1:0] dump_data,
    output logic              dump_sel,
    output logic [IDX_W-1:0]  dump_index,
    output logic              dump_last
);

    state_t           phase;
    logic             region;
    logic [IDX_W-1:0] index;
    logic [IDX_W-1:0] next_index;
    logic             at_region_end;
    logic             accept;

    assign next_index    = index + IDX_W'(1);
    assign at_region_end = (region == DUMP_SEL_MEM) ? (index == IDX_W'(MEM_DEPTH - 1))
                                                    : (index == IDX_W'(REG_COUNT - 1));
    assign accept        = (phase == ST_PRESENT) && dump_ready;
    assign walk_done     = accept && (region == DUMP_SEL_REG) && at_region_end;

    // NOTE: every register here is updated with <= so all of them see the same pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase       <= ST_IDLE;
            region      <= DUMP_SEL_MEM;
            index       <= '0;
            mem_rd_addr <= '0;
            reg_rd_addr <= '0;
            dump_valid  <= 1'b0;
            dump_data   <= '0;
            dump_sel    <= DUMP_SEL_MEM;
            dump_index  <= '0;
            dump_last   <= 1'b0;
        end else begin
            case (phase)
                ST_FETCH: begin
                    phase      <= ST_PRESENT;
                    dump_valid <= 1'b1;
                    dump_data  <= (region == DUMP_SEL_REG) ? reg_rd_data : mem_rd_data;
                    dump_sel   <= region;
                    dump_index <= index;
                    dump_last  <= (region == DUMP_SEL_REG) && at_region_end;
                end
                ST_PRESENT: begin
                    // Outputs stay frozen until the consumer takes the word.
                    if (accept) begin
                        dump_valid <= 1'b0;
                        dump_last  <= 1'b0;
                        if (walk_done) begin
                            phase <= ST_IDLE;
                        end else begin
                            phase <= ST_FETCH;
                            if ((region == DUMP_SEL_MEM) && at_region_end) begin
                                region      <= DUMP_SEL_REG;
                                index       <= '0;
                                reg_rd_addr <= '0;
                            end else begin
                                index <= next_index;
                                if (region == DUMP_SEL_MEM)
                                    mem_rd_addr <= MA_W'(next_index);
                                else
                                    reg_rd_addr <= RA_W'(next_index);
                            end
                        end
                    end
                end
                default: begin
                    if (begin_walk) begin
                        phase       <= ST_FETCH;
                        region      <= DUMP_SEL_MEM;
                        index       <= '0;
                        mem_rd_addr <= '0;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/run_dump_sequencer.sv
// Run controller: holds the core in reset, runs it for a bounded number of cycles,
// then hands off to dump_walker to stream data memory and registers out.
module run_dump_sequencer
    import run_dump_pkg::*;
#(
    parameter  int DATA_W       = 32,
    parameter  int MEM_DEPTH    = 64,
    parameter  int REG_COUNT    = 32,
    parameter  int RESET_CYCLES = 1,
    parameter  int MAX_CYCLES   = 32,
    parameter  int CYC_W        = 16,
    localparam int MA_W         = addr_w(MEM_DEPTH),
    localparam int RA_W         = addr_w(REG_COUNT),
    localparam int IDX_W        = addr_w(max_int(MEM_DEPTH, REG_COUNT)),
    localparam int RC_W         = addr_w(RESET_CYCLES)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              halt,
    output logic              proc_reset,
    output logic              run_en,
    output logic [MA_W-1:0]   mem_rd_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic [RA_W-1:0]   reg_rd_addr,
    input  logic [DATA_W-1:0] reg_rd_data,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [DATA_W-1:0] dump_data,
    output logic              dump_sel,
    output logic [IDX_W-1:0]  dump_index,
    output logic              dump_last,
    output logic              done,
    output logic              timeout,
    output logic [CYC_W-1:0]  cycle_count
);

    state_t          state;
    logic [RC_W-1:0] rst_cnt;
    logic            rst_over;
    logic            at_limit;
    logic            begin_walk;
    logic            walk_done;

    assign rst_over   = (rst_cnt == RC_W'(RESET_CYCLES - 1));
    // The exiting cycle is itself counted, so the limit is hit one below MAX_CYCLES.
    assign at_limit   = (cycle_count == CYC_W'(MAX_CYCLES - 1));
    assign begin_walk = (state == ST_RUN) && (halt || at_limit);

    // ST_FETCH here covers the whole walk; FETCH/PRESENT stepping lives in the walker.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            proc_reset  <= 1'b1;
            run_en      <= 1'b0;
            done        <= 1'b0;
            timeout     <= 1'b0;
            cycle_count <= '0;
            rst_cnt     <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state       <= ST_RST;
                        proc_reset  <= 1'b1;
                        done        <= 1'b0;
                        timeout     <= 1'b0;
                        cycle_count <= '0;
                        rst_cnt     <= '0;
                    end
                end
                ST_RST: begin
                    if (rst_over) begin
                        state      <= ST_RUN;
                        proc_reset <= 1'b0;
                        run_en     <= 1'b1;
                    end else begin
                        rst_cnt <= rst_cnt + RC_W'(1);
                    end
                end
                ST_RUN: begin
                    cycle_count <= cycle_count + CYC_W'(1);
                    if (begin_walk) begin
                        state   <= ST_FETCH;
                        run_en  <= 1'b0;
                        timeout <= !halt;
                    end
                end
                ST_FETCH: begin
                    if (walk_done) begin
                        state      <= ST_DONE;
                        done       <= 1'b1;
                        proc_reset <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    dump_walker #(
        .DATA_W    (DATA_W),
        .MEM_DEPTH (MEM_DEPTH),
        .REG_COUNT (REG_COUNT)
    ) u_walker (
        .clk         (clk),
        .reset       (reset),
        .begin_walk  (begin_walk),
        .walk_done   (walk_done),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data),
        .reg_rd_addr (reg_rd_addr),
        .reg_rd_data (reg_rd_data),
        .dump_valid  (dump_valid),
        .dump_ready  (dump_ready),
        .dump_data   (dump_data),
        .dump_sel    (dump_sel),
        .dump_index  (dump_index),
        .dump_last   (dump_last)
    );

endmodule
